// File: rtl/inertial_interface.sv
// inertial_interface: brings up the 6-axis IMU over SPI, then reads
// pitch rate and Z accel on each data-ready interrupt.
module inertial_interface #(
  parameter int INIT_WAIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  localparam logic [3:0] PWRUP = 4'd0;
  localparam logic [3:0] INIT1 = 4'd1;
  localparam logic [3:0] INIT2 = 4'd2;
  localparam logic [3:0] INIT3 = 4'd3;
  localparam logic [3:0] INIT4 = 4'd4;
  localparam logic [3:0] IDLE  = 4'd5;
  localparam logic [3:0] RD_PL = 4'd6;
  localparam logic [3:0] RD_PH = 4'd7;
  localparam logic [3:0] RD_AL = 4'd8;
  localparam logic [3:0] RD_AH = 4'd9;

  localparam logic [INIT_WAIT_W-1:0] TMR_ONE =
    {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

  logic [3:0]             state;
  logic [INIT_WAIT_W-1:0] timer;
  logic                   int_ff1;
  logic                   int_ff2;
  logic                   int_ff3;
  logic                   int_rise;
  logic [7:0]             pl;
  logic [7:0]             ph;
  logic [7:0]             al;

  // Two-flop synchronizer on INT plus a registered rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1  <= 1'b0;
      int_ff2  <= 1'b0;
      int_ff3  <= 1'b0;
      int_rise <= 1'b0;
    end else begin
      int_ff1  <= INT;
      int_ff2  <= int_ff1;
      int_ff3  <= int_ff2;
      int_rise <= int_ff2 & ~int_ff3;
    end
  end

  // Sequencer: power-up wait, init writes, then 4-byte reads per interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PWRUP;
      timer   <= '0;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
      vld     <= 1'b0;
      pl      <= 8'h00;
      ph      <= 8'h00;
      al      <= 8'h00;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        PWRUP: begin
          if (&timer) begin
            state <= INIT1;
            wrt   <= 1'b1;
            cmd   <= 16'h0D02;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        INIT1: if (done) begin
          state <= INIT2;
          wrt   <= 1'b1;
          cmd   <= 16'h1053;
        end
        INIT2: if (done) begin
          state <= INIT3;
          wrt   <= 1'b1;
          cmd   <= 16'h1150;
        end
        INIT3: if (done) begin
          state <= INIT4;
          wrt   <= 1'b1;
          cmd   <= 16'h1460;
        end
        INIT4: if (done) begin
          state <= IDLE;
        end
        IDLE: if (int_rise) begin
          state <= RD_PL;
          wrt   <= 1'b1;
          cmd   <= 16'hA200;
        end
        RD_PL: if (done) begin
          pl    <= rd_data[7:0];
          state <= RD_PH;
          wrt   <= 1'b1;
          cmd   <= 16'hA300;
        end
        RD_PH: if (done) begin
          ph    <= rd_data[7:0];
          state <= RD_AL;
          wrt   <= 1'b1;
          cmd   <= 16'hAC00;
        end
        RD_AL: if (done) begin
          al    <= rd_data[7:0];
          state <= RD_AH;
          wrt   <= 1'b1;
          cmd   <= 16'hAD00;
        end
        RD_AH: if (done) begin
          state   <= IDLE;
          ptch_rt <= {ph, pl};
          AZ      <= {rd_data[7:0], al};
          vld     <= 1'b1;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_inertial_interface.sv
// tb_inertial_interface: scoreboard bench with an SPI responder model,
// directed reads with hand-computed words, INT filtering and reset abort.
module tb_inertial_interface;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  inertial_interface #(.INIT_WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT),
    .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd),
    .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_cmd[$];
  logic [7:0]  rsp[$];
  logic [31:0] exp_out[$];

  int n_wrt = 0;
  int n_srv = 0;
  int n_vld = 0;
  logic [15:0] cur_pt = 16'h0;
  logic [15:0] cur_az = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // SPI responder: done 8 cycles after wrt, cmd checked stable meanwhile
  initial begin : spi_model
    logic [15:0] c;
    logic [7:0]  b;
    logic        ab;
    done = 1'b0;
    rd_data = 16'h0;
    forever begin
      if (wrt && rst_n) begin
        c = cmd;
        ab = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
          chk("cmd_stable", {16'h0, cmd}, {16'h0, c});
        end
        if (!ab) begin
          b = 8'h00;
          if (c[15]) begin
            if (rsp.size() == 0) fail_now("rsp_underflow");
            else b = rsp.pop_front();
          end
          rd_data = {8'hEE, b};
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
          rd_data = 16'h0;
          n_srv++;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Monitor: pops expected cmds on wrt, expected words on vld
  initial begin : monitor
    logic pw;
    logic pv;
    logic [31:0] e;
    pw = 1'b0;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (wrt) begin
        n_wrt++;
        if (pw) fail_now("wrt_width");
        if (exp_cmd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wrt: got cmd %h want none", cmd);
        end else begin
          chk("cmd", {16'h0, cmd}, {16'h0, exp_cmd.pop_front()});
        end
      end
      if (vld) begin
        n_vld++;
        if (pv) fail_now("vld_width");
        if (exp_out.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vld: got %h %h", ptch_rt, AZ);
        end else begin
          e = exp_out.pop_front();
          chk("ptch_rt", {16'h0, ptch_rt}, {16'h0, e[31:16]});
          chk("AZ", {16'h0, AZ}, {16'h0, e[15:0]});
          cur_pt = e[31:16];
          cur_az = e[15:0];
        end
      end else begin
        chk("hold", {ptch_rt, AZ}, {cur_pt, cur_az});
      end
      pw = wrt;
      pv = vld;
    end
  end

  task automatic wait_ge(input string nm, input int which,
                         input int target);
    int v;
    for (int i = 0; i < 400; i++) begin
      case (which)
        0: v = n_wrt;
        1: v = n_srv;
        default: v = n_vld;
      endcase
      if (v >= target) return;
      @(negedge clk);
    end
    fail_now({"timeout_", nm});
  endtask

  task automatic meas_wrt(input string nm, input int req);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (wrt) break;
    end
    chk(nm, n, req);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wrt"}, {31'h0, wrt}, 32'h0);
    chk({nm, "_cmd"}, {16'h0, cmd}, 32'h0);
    chk({nm, "_pt"}, {16'h0, ptch_rt}, 32'h0);
    chk({nm, "_az"}, {16'h0, AZ}, 32'h0);
    chk({nm, "_vld"}, {31'h0, vld}, 32'h0);
  endtask

  task automatic push_init();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_read(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [31:0] w);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
    rsp.push_back(b0);
    rsp.push_back(b1);
    rsp.push_back(b2);
    rsp.push_back(b3);
    exp_out.push_back(w);
  endtask

  task automatic pulse_int(input int hi);
    INT = 1'b1;
    repeat (hi) @(negedge clk);
    INT = 1'b0;
  endtask

  initial begin : stim
    int base;
    rst_n = 1'b0;
    INT = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");

    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    meas_wrt("pwrup_lat", 16);
    wait_ge("init", 1, 4);
    chk("init_drained", exp_cmd.size(), 0);
    repeat (5) @(negedge clk);

    push_read(8'h34, 8'h12, 8'h78, 8'h56, 32'h1234_5678);
    INT = 1'b1;
    meas_wrt("int_lat", 4);
    wait_ge("rd1", 2, 1);
    repeat (30) @(negedge clk);
    INT = 1'b0;
    repeat (5) @(negedge clk);

    push_read(8'hFF, 8'hF0, 8'h00, 8'h80, 32'hF0FF_8000);
    INT = 1'b1;
    meas_wrt("int_lat2", 4);
    wait_ge("rd2", 2, 2);
    INT = 1'b0;
    repeat (5) @(negedge clk);

    push_read(8'h01, 8'h02, 8'h03, 8'h04, 32'h0201_0403);
    base = n_wrt;
    pulse_int(2);
    wait_ge("rd3_al", 0, base + 3);
    pulse_int(2);
    wait_ge("rd3", 2, 3);
    repeat (30) @(negedge clk);
    chk("rd3_vld_cnt", n_vld, 3);

    push_read(8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'h0);
    void'(exp_out.pop_back());
    base = n_srv;
    pulse_int(2);
    wait_ge("rd4_ph", 1, base + 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cur_pt = 16'h0;
    cur_az = 16'h0;
    exp_cmd.delete();
    rsp.delete();
    #1;
    chk_zero("abort");
    repeat (3) @(negedge clk);

    push_init();
    rst_n = 1'b1;
    base = n_wrt;
    meas_wrt("pwrup_lat2", 16);
    wait_ge("init2_i2", 0, base + 2);
    pulse_int(2);
    base = n_srv;
    wait_ge("init2", 1, base + 3);
    repeat (30) @(negedge clk);
    chk("init2_drained", exp_cmd.size(), 0);
    chk("pt_after_rst", {16'h0, ptch_rt}, 32'h0);

    push_read(8'h11, 8'h22, 8'h33, 8'h44, 32'h2211_4433);
    base = n_vld;
    pulse_int(2);
    wait_ge("rd5", 2, base + 1);
    repeat (10) @(negedge clk);

    chk("cmd_q_empty", exp_cmd.size(), 0);
    chk("out_q_empty", exp_out.size(), 0);
    chk("vld_total", n_vld, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
